// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM encoding and PC constants.
package fetch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_VALID = 3'd3,
        ST_HALT  = 3'd4
    } fetch_state_e;

    localparam int          WORD_BITWIDTH_DEF = 32;
    localparam logic [31:0] RESET_PC_DEF      = 32'h0000_0000;
    localparam int          PC_INC            = 4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch bundle: redirect input, instruction-memory handshake and decode-side valid/ready.
// master = fetch controller, slave = environment (memory, decode, branch unit).
interface fetch_ctrl_if #(
    parameter int WORD_BITWIDTH = 32
);
    logic                     redirect_valid;
    logic [WORD_BITWIDTH-1:0] redirect_pc;
    logic                     imem_req;
    logic [WORD_BITWIDTH-1:0] imem_addr;
    logic                     imem_gnt;
    logic                     imem_rvalid;
    logic [WORD_BITWIDTH-1:0] imem_rdata;
    logic                     inst_valid;
    logic [WORD_BITWIDTH-1:0] inst_pc;
    logic [WORD_BITWIDTH-1:0] inst_data;
    logic                     inst_ready;
    logic                     fetch_fault;

    modport master (
        input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        output imem_req, imem_addr, inst_valid, inst_pc, inst_data, fetch_fault
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, inst_ready,
        input  imem_req, imem_addr, inst_valid, inst_pc, inst_data, fetch_fault
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Single-outstanding instruction fetch sequencer with redirect squashing.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects into a sticky HALT with fetch_fault.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                       WORD_BITWIDTH = WORD_BITWIDTH_DEF,
    parameter logic [WORD_BITWIDTH-1:0] RESET_PC      = WORD_BITWIDTH'(RESET_PC_DEF)
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_ctrl_if.master  bus
);

    localparam logic [WORD_BITWIDTH-1:0] PC_STEP    = WORD_BITWIDTH'(PC_INC);
    localparam logic [WORD_BITWIDTH-1:0] ALIGN_MASK = ~WORD_BITWIDTH'(3);

    fetch_state_e             r_state;
    fetch_state_e             w_state_nxt;
    logic [WORD_BITWIDTH-1:0] r_pc;
    logic [WORD_BITWIDTH-1:0] r_inst_pc;
    logic [WORD_BITWIDTH-1:0] r_inst_data;
    logic                     r_kill;
    logic                     r_fault;
    logic                     w_redir;
    logic                     w_trap;
    logic [WORD_BITWIDTH-1:0] w_redir_pc;

    // Redirects are only honoured once the sequencer is live; IDLE and HALT ignore them.
    assign w_redir = bus.redirect_valid && (r_state inside {ST_REQ, ST_WAIT, ST_VALID});

`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_redir_pc = bus.redirect_pc;
    assign w_trap     = w_redir && (bus.redirect_pc[1:0] != 2'b00);
`else
    assign w_redir_pc = bus.redirect_pc & ALIGN_MASK;
    assign w_trap     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = ST_REQ;
            ST_REQ:   if (bus.imem_gnt) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (bus.imem_rvalid) begin
                    w_state_nxt = (r_kill || w_redir) ? ST_REQ : ST_VALID;
                end
            end
            ST_VALID: if (w_redir || bus.inst_ready) w_state_nxt = ST_REQ;
            ST_HALT:  w_state_nxt = ST_HALT;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (w_trap) w_state_nxt = ST_HALT;
    end

    // A granted-but-redirected fetch is marked with kill so its response is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc        <= RESET_PC;
            r_kill      <= 1'b0;
            r_inst_pc   <= '0;
            r_inst_data <= '0;
            r_fault     <= 1'b0;
        end else if (w_trap) begin
            r_fault <= 1'b1;
            r_kill  <= 1'b0;
        end else begin
            if (w_redir) begin
                r_pc <= w_redir_pc;
            end else if (r_state == ST_VALID && bus.inst_ready) begin
                r_pc <= r_pc + PC_STEP;
            end
            case (r_state)
                ST_REQ: begin
                    if (bus.imem_gnt && w_redir) r_kill <= 1'b1;
                end
                ST_WAIT: begin
                    if (bus.imem_rvalid) begin
                        r_kill <= 1'b0;
                        if (!r_kill && !w_redir) begin
                            r_inst_data <= bus.imem_rdata;
                            r_inst_pc   <= r_pc;
                        end
                    end else if (w_redir) begin
                        r_kill <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.imem_req    = (r_state == ST_REQ);
        bus.imem_addr   = r_pc;
        bus.inst_valid  = (r_state == ST_VALID);
        bus.inst_pc     = r_inst_pc;
        bus.inst_data   = r_inst_data;
        bus.fetch_fault = r_fault;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: transaction-level PC-stream model plus literal spot checks.
module tb_fetch_ctrl;

    localparam logic [31:0] MAIN_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_RESET_PC = 32'hFFFF_FFFC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    fetch_ctrl_if #(.WORD_BITWIDTH(32)) bus  ();
    fetch_ctrl_if #(.WORD_BITWIDTH(32)) bus2 ();

    fetch_ctrl #(.WORD_BITWIDTH(32), .RESET_PC(MAIN_RESET_PC)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fetch_ctrl #(.WORD_BITWIDTH(32), .RESET_PC(WRAP_RESET_PC)) u_dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial forever #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;
    int rv_delay = 1;
    logic [31:0] wrap_q[$];

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a + 32'h13;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_req(input string nm);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.imem_req && k < 60);
        if (!bus.imem_req) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_valid(input string nm);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.inst_valid && k < 60);
        if (!bus.inst_valid) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Memory responder for the main DUT: one response rv_delay cycles after each grant.
    initial begin
        bit          grant_now;
        bit          pend;
        int          cnt;
        logic [31:0] paddr;
        logic [31:0] gaddr;
        pend = 0;
        cnt = 0;
        paddr = '0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(negedge clk);
            grant_now = bus.imem_req && bus.imem_gnt && rst_n;
            gaddr     = bus.imem_addr;
            tick();
            bus.imem_rvalid = 1'b0;
            if (grant_now) begin
                pend  = 1;
                cnt   = rv_delay;
                paddr = gaddr;
            end
            if (pend) begin
                if (cnt <= 1) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = mem(paddr);
                    pend = 0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Second instance: always granted, always ready, one-cycle response; only the address order matters.
    initial begin
        bit          g2;
        logic [31:0] a2;
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        bus2.imem_gnt       = 1'b1;
        bus2.inst_ready     = 1'b1;
        bus2.imem_rvalid    = 1'b0;
        bus2.imem_rdata     = '0;
        forever begin
            @(negedge clk);
            g2 = bus2.imem_req && rst_n;
            a2 = bus2.imem_addr;
            if (g2) wrap_q.push_back(a2);
            tick();
            bus2.imem_rvalid = g2;
            bus2.imem_rdata  = mem(a2);
        end
    end

    // Model: the decode-visible PC stream advances by 4 on each accepted instruction
    // and jumps to the target on a redirect; every delivered word is mem(pc).
    initial begin
        logic [31:0] exp_pc;
        bit          exp_fault;
        bit          prev_hold;
        exp_pc = MAIN_RESET_PC;
        exp_fault = 0;
        prev_hold = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_req",   {31'd0, bus.imem_req},    32'd0);
                chk("rst_valid", {31'd0, bus.inst_valid},  32'd0);
                chk("rst_pc",    bus.inst_pc,              32'd0);
                chk("rst_data",  bus.inst_data,            32'd0);
                chk("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
                exp_pc = MAIN_RESET_PC;
                exp_fault = 0;
                prev_hold = 0;
            end else begin
                if (exp_fault) begin
                    chk("halt_fault", {31'd0, bus.fetch_fault}, 32'd1);
                    chk("halt_req",   {31'd0, bus.imem_req},    32'd0);
                    chk("halt_valid", {31'd0, bus.inst_valid},  32'd0);
                end else begin
                    chk("fault_low", {31'd0, bus.fetch_fault}, 32'd0);
                    if (prev_hold) chk("hold_valid", {31'd0, bus.inst_valid}, 32'd1);
                    if (bus.inst_valid) begin
                        chk("model_inst_pc",   bus.inst_pc,           exp_pc);
                        chk("model_inst_data", bus.inst_data,         mem(exp_pc));
                        chk("model_no_req",    {31'd0, bus.imem_req}, 32'd0);
                    end
                    if (bus.imem_req && bus.imem_gnt && !bus.redirect_valid)
                        chk("model_imem_addr", bus.imem_addr, exp_pc);
                end
                prev_hold = bus.inst_valid && !bus.inst_ready && !bus.redirect_valid && !exp_fault;
                if (bus.redirect_valid && !exp_fault) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (bus.redirect_pc[1:0] != 2'b00) exp_fault = 1;
                    else exp_pc = bus.redirect_pc;
`else
                    exp_pc = bus.redirect_pc & 32'hFFFF_FFFC;
`endif
                end else if (bus.inst_valid && bus.inst_ready) begin
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_pc;
        logic [31:0] held_data;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_gnt       = 1'b0;
        bus.inst_ready     = 1'b0;
        repeat (3) tick();

        // 1: back-to-back fetch with minimum latency
        rst_n = 1'b1;
        bus.imem_gnt   = 1'b1;
        bus.inst_ready = 1'b1;
        wait_req("t1_req0");
        chk("t1_addr0", bus.imem_addr, 32'h0);
        @(negedge clk);
        chk("t1_wait_req",   {31'd0, bus.imem_req},   32'd0);
        chk("t1_wait_valid", {31'd0, bus.inst_valid}, 32'd0);
        @(negedge clk);
        chk("t1_valid", {31'd0, bus.inst_valid}, 32'd1);
        chk("t1_pc",    bus.inst_pc,   32'h0);
        chk("t1_data",  bus.inst_data, 32'h13);
        @(negedge clk);
        chk("t1_req1",  {31'd0, bus.imem_req}, 32'd1);
        chk("t1_addr1", bus.imem_addr, 32'h4);
        wait_req("t1_req2");
        chk("t1_addr2", bus.imem_addr, 32'h8);

        // 2: decode stall in VALID
        tick();
        bus.inst_ready = 1'b0;
        wait_valid("t2_valid");
        chk("t2_pc",   bus.inst_pc,   32'h8);
        chk("t2_data", bus.inst_data, 32'h1B);
        held_pc   = bus.inst_pc;
        held_data = bus.inst_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", {31'd0, bus.inst_valid}, 32'd1);
            chk("t2_hold_pc",    bus.inst_pc,   held_pc);
            chk("t2_hold_data",  bus.inst_data, held_data);
            chk("t2_hold_noreq", {31'd0, bus.imem_req}, 32'd0);
        end
        tick();
        bus.inst_ready = 1'b1;
        rv_delay = 3;

        // 3: redirect while waiting for data
        wait_req("t3_req");
        chk("t3_addr_old", bus.imem_addr, 32'hC);
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        tick();
        bus.redirect_valid = 1'b0;
        wait_req("t3_req_new");
        chk("t3_addr_new", bus.imem_addr, 32'h100);
        wait_valid("t3_valid");
        chk("t3_pc",   bus.inst_pc,   32'h100);
        chk("t3_data", bus.inst_data, 32'h113);
        tick();
        rv_delay = 1;
        bus.imem_gnt = 1'b0;

        // 4: redirect in the same cycle as the grant
        wait_req("t4_req");
        chk("t4_addr_old", bus.imem_addr, 32'h104);
        tick();
        bus.imem_gnt       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        tick();
        bus.redirect_valid = 1'b0;
        wait_req("t4_req_new");
        chk("t4_addr_new", bus.imem_addr, 32'h40);
        wait_valid("t4_valid");
        chk("t4_pc",   bus.inst_pc,   32'h40);
        chk("t4_data", bus.inst_data, 32'h53);

        // reset abandons an in-flight request; its late response lands in IDLE
        rv_delay = 2;
        wait_req("rst_mid_req");
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_req",   {31'd0, bus.imem_req},   32'd0);
        chk("rst_mid_valid", {31'd0, bus.inst_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        wait_req("rst_after_req");
        chk("rst_after_addr", bus.imem_addr, 32'h0);
        wait_valid("rst_after_valid");
        chk("rst_after_pc",   bus.inst_pc,   32'h0);
        chk("rst_after_data", bus.inst_data, 32'h13);
        rv_delay = 1;

        // 6: misaligned redirect
        wait_req("t6_req");
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h102;
        tick();
        bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_fault", {31'd0, bus.fetch_fault}, 32'd1);
            chk("t6_noreq", {31'd0, bus.imem_req},    32'd0);
        end
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_fault_clr", {31'd0, bus.fetch_fault}, 32'd0);
        tick();
        rst_n = 1'b1;
        wait_req("t6_req_after");
        chk("t6_addr_after", bus.imem_addr, 32'h0);
`else
        wait_req("t6_req_new");
        chk("t6_addr_aligned", bus.imem_addr, 32'h100);
        chk("t6_fault_tied",   {31'd0, bus.fetch_fault}, 32'd0);
        wait_valid("t6_valid");
        chk("t6_pc", bus.inst_pc, 32'h100);
`endif

        // 5: PC wrap on the second instance
        chk("t5_count", (wrap_q.size() >= 2) ? 32'd1 : 32'd0, 32'd1);
        if (wrap_q.size() >= 2) begin
            chk("t5_addr0", wrap_q[0], 32'hFFFF_FFFC);
            chk("t5_addr1", wrap_q[1], 32'h0000_0000);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
